fp_adder_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational floating-point adder. It adds or subtracts two sign-magnitude floating-point operands with configurable exponent and fraction widths. The datapath is a three-stage valid/ready pipeline with full backpressure, throughput of one result per cycle, and explicit overflow/underflow flags. It sits between the operand-issue logic and the result writeback of the arithmetic datapath.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_lzc.sv | 26 ++
 rtl/fp_adder_pipe.sv | 178 +++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fp_pkg
// Brief    : Shared widths and packed types for the pipelined FP adder.
// Revision : 1.0 - initial release
// =============================================================================
package fp_pkg;

    localparam int FP_EXP_W  = 4;
    localparam int FP_FRAC_W = 8;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fp_flags_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_t;

    function automatic fp_t fp_make(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exp,
        input logic [FP_FRAC_W-1:0] frac
    );
        fp_t v;
        v.sign = sign;
        v.exp  = exp;
        v.frac = frac;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// =============================================================================
// Module   : fp_lzc
// Brief    : Leading-zero counter; an all-zero input returns W.
// Revision : 1.0 - initial release
// =============================================================================
module fp_lzc #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_count
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module   : fp_adder_pipe
// Brief    : Three-stage valid/ready sign-magnitude FP adder/subtractor.
// Revision : 1.0 - initial release
// =============================================================================
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  exp1,
    input  logic [EXP_W-1:0]  exp2,
    input  logic [FRAC_W-1:0] frac1,
    input  logic [FRAC_W-1:0] frac2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ovf,
    output logic              udf
);

    localparam int LZ_W = $clog2(FRAC_W + 1);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } res_t;

    // Stage handshake: a stage loads when it is empty or its successor loads.
    logic w_ld1, w_ld2, w_ld3;
    logic r_s1_valid, r_s2_valid, r_s3_valid;

    assign w_ld3    = !r_s3_valid || out_ready;
    assign w_ld2    = !r_s2_valid || w_ld3;
    assign w_ld1    = !r_s1_valid || w_ld2;
    assign in_ready = w_ld1;

    // S1: sort and align
    logic              w_op1_big;
    logic              w_sign_b;
    logic              w_sub;
    logic [EXP_W-1:0]  w_exp_b, w_exp_s, w_diff;
    logic [FRAC_W-1:0] w_frac_b, w_frac_s, w_aligned;

    assign w_op1_big = {exp1, frac1} > {exp2, frac2};
    assign w_sign_b  = w_op1_big ? sign1 : sign2;
    assign w_exp_b   = w_op1_big ? exp1  : exp2;
    assign w_exp_s   = w_op1_big ? exp2  : exp1;
    assign w_frac_b  = w_op1_big ? frac1 : frac2;
    assign w_frac_s  = w_op1_big ? frac2 : frac1;
    assign w_sub     = sign1 ^ sign2;
    assign w_diff    = w_exp_b - w_exp_s;
    assign w_aligned = (32'(w_diff) >= 32'(FRAC_W)) ? '0 : (w_frac_s >> w_diff);

    logic              r_s1_sign, r_s1_sub;
    logic [EXP_W-1:0]  r_s1_expb;
    logic [FRAC_W-1:0] r_s1_fracb, r_s1_fracs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_expb  <= '0;
            r_s1_fracb <= '0;
            r_s1_fracs <= '0;
        end else if (w_ld1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= w_sign_b;
                r_s1_sub   <= w_sub;
                r_s1_expb  <= w_exp_b;
                r_s1_fracb <= w_frac_b;
                r_s1_fracs <= w_aligned;
            end
        end
    end

    // S2: magnitude add or subtract; big operand dominates so no sign flip
    logic [FRAC_W:0] w_sum;

    assign w_sum = r_s1_sub ? ({1'b0, r_s1_fracb} - {1'b0, r_s1_fracs})
                            : ({1'b0, r_s1_fracb} + {1'b0, r_s1_fracs});

    logic             r_s2_sign;
    logic [EXP_W-1:0] r_s2_expb;
    logic [FRAC_W:0]  r_s2_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_expb  <= '0;
            r_s2_sum   <= '0;
        end else if (w_ld2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_expb <= r_s1_expb;
                r_s2_sum  <= w_sum;
            end
        end
    end

    // S3: normalise and pack
    logic [LZ_W-1:0] w_lead;
    res_t            w_res;
    fp_flags_t       w_flags;

    fp_lzc #(
        .W     (FRAC_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data  (r_s2_sum[FRAC_W-1:0]),
        .o_count (w_lead)
    );

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (r_s2_sum[FRAC_W]) begin
            w_res.sign = r_s2_sign;
            if (&r_s2_expb) begin
                w_res.exp   = '1;
                w_res.frac  = '1;
                w_flags.ovf = 1'b1;
            end else begin
                w_res.exp  = r_s2_expb + EXP_W'(1);
                w_res.frac = r_s2_sum[FRAC_W:1];
            end
        end else if (r_s2_sum == '0) begin
            w_flags = '0;
        end else if (32'(w_lead) <= 32'(r_s2_expb)) begin
            w_res.sign = r_s2_sign;
            w_res.exp  = r_s2_expb - EXP_W'(w_lead);
            w_res.frac = r_s2_sum[FRAC_W-1:0] << w_lead;
        end else begin
            w_flags.udf = 1'b1;
        end
    end

    res_t      r_s3_res;
    fp_flags_t r_s3_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
            r_s3_res   <= '0;
            r_s3_flags <= '0;
        end else if (w_ld3) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_res   <= w_res;
                r_s3_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign sign_out  = r_s3_res.sign;
    assign exp_out   = r_s3_res.exp;
    assign frac_out  = r_s3_res.frac;
    assign ovf       = r_s3_flags.ovf;
    assign udf       = r_s3_flags.udf;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_fp_adder_pipe
// Brief    : Scoreboard bench for fp_adder_pipe with directed operand table.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fp_adder_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic       sign1, sign2;
    logic [3:0] exp1, exp2;
    logic [7:0] frac1, frac2;
    logic       out_valid, out_ready;
    logic       sign_out;
    logic [3:0] exp_out;
    logic [7:0] frac_out;
    logic       ovf, udf;

    always #5 clk = ~clk;

    fp_adder_pipe #(.EXP_W(4), .FRAC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign1     (sign1),
        .sign2     (sign2),
        .exp1      (exp1),
        .exp2      (exp2),
        .frac1     (frac1),
        .frac2     (frac2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .ovf       (ovf),
        .udf       (udf)
    );

    // Result word: {sign, exp, frac, ovf, udf}
    wire [14:0] w_obs = {sign_out, exp_out, frac_out, ovf, udf};

    logic [14:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [25:0] ops [8];
    logic [14:0] res [8];

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Output monitor: runs after the driver has settled inputs for the next edge.
    logic        hold_prev = 1'b0;
    logic [14:0] held = '0;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_stable", w_obs, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
                else check("result", w_obs, exp_q.pop_front());
            end
            hold_prev = out_valid && !out_ready;
            held      = w_obs;
        end
    end

    task automatic send(input logic [25:0] op, input logic [14:0] e, input bit track);
        int guard = 0;
        bit ok    = 1'b0;
        {sign1, exp1, frac1, sign2, exp2, frac2} = op;
        in_valid = 1'b1;
        if (track) exp_q.push_back(e);
        while (!ok && guard < 50) begin
            #1;
            ok = in_ready;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", in_ready, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        ops[0] = {1'b0, 4'd3,  8'h80, 1'b0, 4'd3,  8'h80}; res[0] = {1'b0, 4'd4,  8'h80, 2'b00};
        ops[1] = {1'b0, 4'd4,  8'h80, 1'b0, 4'd2,  8'h80}; res[1] = {1'b0, 4'd4,  8'hA0, 2'b00};
        ops[2] = {1'b0, 4'd9,  8'h80, 1'b0, 4'd0,  8'hFF}; res[2] = {1'b0, 4'd9,  8'h80, 2'b00};
        ops[3] = {1'b0, 4'd5,  8'hC0, 1'b1, 4'd5,  8'h80}; res[3] = {1'b0, 4'd4,  8'h80, 2'b00};
        ops[4] = {1'b1, 4'd6,  8'h90, 1'b0, 4'd6,  8'h90}; res[4] = {1'b0, 4'd0,  8'h00, 2'b00};
        ops[5] = {1'b0, 4'd15, 8'h80, 1'b0, 4'd15, 8'h80}; res[5] = {1'b0, 4'd15, 8'hFF, 2'b10};
        ops[6] = {1'b0, 4'd1,  8'h80, 1'b1, 4'd1,  8'h7F}; res[6] = {1'b0, 4'd0,  8'h00, 2'b01};
        ops[7] = {1'b1, 4'd3,  8'hC0, 1'b0, 4'd2,  8'h80}; res[7] = {1'b1, 4'd3,  8'h80, 2'b00};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        {sign1, exp1, frac1, sign2, exp2, frac2} = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", w_obs, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // Latency of a single carry case
        send(ops[0], res[0], 1'b1);
        check("lat_c1", out_valid, 0);
        @(negedge clk);
        check("lat_c2", out_valid, 0);
        @(negedge clk);
        check("lat_c3", out_valid, 1);
        drain();

        // Back-to-back directed cases
        for (int i = 1; i < 8; i++) send(ops[i], res[i], 1'b1);
        drain();

        // Backpressure: consumer stalls for cycles 4-7 of the stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(ops[i], res[i], 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight; neither may ever emerge
        send(ops[1], res[1], 1'b0);
        send(ops[2], res[2], 1'b0);
        check("pre_rst_out_valid", out_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_outputs", w_obs, 0);
        check("mid_rst_in_ready", in_ready, 1);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_idle", out_valid, 0);

        // Pipe still works after the flush
        send(ops[7], res[7], 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
